// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the repeated-addition multiplier
// and its operand sequencer front end.
package mul_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_WAIT   = 3'd4,
        ST_HOLD   = 3'd5
    } state_e;

    function automatic int wd_bits(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mul_operand_sequencer_if.sv
// Operand-in, multiplier-side and result-out signals of the sequencer.
// The sequencer is the slave side; the environment is the master side.
interface mul_operand_sequencer_if #(
    parameter int WIDTH = mul_pkg::WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             mul_start;
    logic [WIDTH-1:0] mul_data;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_product;
    logic             out_timeout;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b,
        input  mul_done, mul_product,
        input  out_ready,
        output in_ready, mul_start, mul_data,
        output out_valid, out_product, out_timeout,
        output busy
    );

    modport master (
        output in_valid, in_a, in_b,
        output mul_done, mul_product,
        output out_ready,
        input  in_ready, mul_start, mul_data,
        input  out_valid, out_product, out_timeout,
        input  busy
    );

endinterface

// File: rtl/mul_operand_fifo.sv
// Two-entry operand-pair buffer between the input handshake and the FSM.
// A push is accepted when full only if a pop happens in the same cycle.
module mul_operand_fifo #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [1:0]    count_q, count_d;
    logic          wptr_q;
    logic          rptr_q;
    logic [DW-1:0] mem_q [2];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds operand pairs to the repeated-addition multiplier (A then B on the
// shared data bus), waits for done or the watchdog, and holds the result.
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    mul_operand_sequencer_if.slave bus
);

    localparam int             WDW      = wd_bits(TIMEOUT);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   prod_q;
    logic [WDW-1:0]     wd_q;
    logic               start_q;
    logic               valid_q;
    logic               tout_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    assign push = bus.in_valid && !fifo_full;

    // A stale done from the previous job must drop before the next issue.
    assign pop = (state_q == ST_IDLE) && !fifo_empty
              && !bus.mul_done && !valid_q;

    mul_operand_fifo #(
        .DW (2*WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.in_a, bus.in_b}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            prod_q  <= '0;
            wd_q    <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        a_q     <= head[2*WIDTH-1 -: WIDTH];
                        b_q     <= head[WIDTH-1:0];
                        data_q  <= head[2*WIDTH-1 -: WIDTH];
                        wd_q    <= '0;
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    start_q <= 1'b0;
                    data_q  <= a_q;
                    state_q <= ST_LOAD_A;
                end
                ST_LOAD_A: begin
                    data_q  <= b_q;
                    state_q <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mul_done) begin
                        prod_q  <= bus.mul_product;
                        tout_q  <= 1'b0;
                        valid_q <= 1'b1;
                        data_q  <= '0;
                        state_q <= ST_HOLD;
                    end else if (wd_q == WD_LIMIT) begin
                        prod_q  <= '0;
                        tout_q  <= 1'b1;
                        valid_q <= 1'b1;
                        data_q  <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = !fifo_full;
    assign bus.mul_start   = start_q;
    assign bus.mul_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_product = prod_q;
    assign bus.out_timeout = tout_q;
    assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty || valid_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer: multiplier stub, result monitor and
// a queue-of-pairs reference model (product = a*b mod 2^16).
module tb_mul_operand_sequencer;

    localparam int W  = 16;
    localparam int TO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_operand_sequencer_if #(.WIDTH(W)) bus ();

    mul_operand_sequencer #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model and observed results
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_p [$];
    bit           got_t [$];

    // Multiplier stub: latches A/B off the shared bus, runs b+1+extra cycles
    int           stub_extra = 0;
    int           stub_hold  = 1;
    int           stub_force = -1;
    bit           stub_never = 0;
    logic [W-1:0] s_a, s_b;
    int           s_run;
    bit           s_abort;

    initial begin
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mul_start) begin
                s_abort = 0;
                @(negedge clk);
                s_a = bus.mul_data;
                s_abort = !rst_n;
                @(negedge clk);
                s_b = bus.mul_data;
                s_abort = s_abort || !rst_n;
                s_run = (stub_force >= 0) ? stub_force : int'(s_b) + 1 + stub_extra;
                if (!stub_never) begin
                    for (int i = 0; i < s_run && !s_abort; i++) begin
                        @(negedge clk);
                        if (!rst_n) s_abort = 1;
                    end
                    if (!s_abort) begin
                        bus.mul_done    = 1'b1;
                        bus.mul_product = W'(32'(s_a) * 32'(s_b));
                        for (int i = 0; i < stub_hold && rst_n; i++) @(negedge clk);
                        bus.mul_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                got_p.push_back(bus.out_product);
                got_t.push_back(bus.out_timeout);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "hung");
    end

    task automatic clear_q();
        exp_q.delete();
        got_p.delete();
        got_t.delete();
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        #1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL push_accept a=%0d b=%0d in_ready=%b want 1", a, b, bus.in_ready);
        end
        exp_q.push_back(W'(32'(a) * 32'(b)));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n, input string tag);
        int c = 0;
        while (got_p.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (got_p.size() < n) begin
            errors++;
            $display("FAIL %s_wait got %0d results want %0d", tag, got_p.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b want 0", bus.mul_start); end
        checks++; if (bus.mul_data !== '0) begin errors++; $display("FAIL reset_mul_data got %0d want 0", bus.mul_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_product !== '0) begin errors++; $display("FAIL reset_out_product got %0d want 0", bus.out_product); end
        checks++; if (bus.out_timeout !== 1'b0) begin errors++; $display("FAIL reset_out_timeout got %b want 0", bus.out_timeout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int n = 0;
        int lat = 0;
        clear_q();
        stub_extra    = 0;
        stub_hold     = 1;
        bus.out_ready = 1'b1;
        push_pair(16'd5, 16'd6);
        #1;
        while (!bus.mul_start && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (bus.mul_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b want 1", bus.mul_start); end
        checks++; if (bus.mul_data !== 16'd5) begin errors++; $display("FAIL basic_data_start got %0d want 5", bus.mul_data); end
        @(negedge clk); #1;
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL basic_start_width got %b want 0", bus.mul_start); end
        checks++; if (bus.mul_data !== 16'd5) begin errors++; $display("FAIL basic_data_load_a got %0d want 5", bus.mul_data); end
        @(negedge clk); #1;
        checks++; if (bus.mul_data !== 16'd6) begin errors++; $display("FAIL basic_data_load_b got %0d want 6", bus.mul_data); end
        @(negedge clk); #1;
        checks++; if (bus.mul_data !== 16'd6) begin errors++; $display("FAIL basic_data_wait got %0d want 6", bus.mul_data); end
        while (!bus.out_valid && lat < 40) begin @(negedge clk); #1; lat++; end
        checks++; if (lat != 7) begin errors++; $display("FAIL basic_latency got %0d want 7", lat); end
        checks++; if (bus.out_product !== 16'd30) begin errors++; $display("FAIL basic_product got %0d want 30", bus.out_product); end
        checks++; if (bus.out_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", bus.out_timeout); end
        @(negedge clk);
        wait_res(1, "basic");
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c = 0;
        clear_q();
        bus.out_ready = 1'b0;
        push_pair(16'd3, 16'd4);
        push_pair(16'd7, 16'd2);
        push_pair(16'd9, 16'd9);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full got %b want 0", bus.in_ready); end
        while (!bus.out_valid && c < 60) begin @(negedge clk); #1; c++; end
        repeat (3) begin @(negedge clk); #1; end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_held got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", bus.out_valid); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        wait_res(3, "b2b");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got_p.size() || got_p[i] !== exp_q[i] || got_t[i] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result[%0d] got %0d want %0d", i, (i < got_p.size()) ? got_p[i] : 16'hxxxx, exp_q[i]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_zero();
        clear_q();
        bus.out_ready = 1'b1;
        push_pair(16'd8, 16'd0);
        push_pair(16'd0, 16'd5);
        wait_res(2, "zero");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_p.size() || got_p[i] !== exp_q[i] || got_t[i] !== 1'b0) begin
                errors++;
                $display("FAIL zero_result[%0d] got %0d/%0b want %0d/0", i, (i < got_p.size()) ? got_p[i] : 16'hxxxx, (i < got_t.size()) ? got_t[i] : 1'b1, exp_q[i]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int c = 0;
        clear_q();
        bus.out_ready = 1'b0;
        push_pair(16'd2, 16'd3);
        #1;
        while (!bus.out_valid && c < 60) begin @(negedge clk); #1; c++; end
        @(negedge clk);
        push_pair(16'd4, 16'd5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_product !== 16'd6) begin errors++; $display("FAIL bp_product[%0d] got %0d want 6", i, bus.out_product); end
            checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL bp_no_start[%0d] got %b want 0", i, bus.mul_start); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        wait_res(2, "bp");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_p.size() || got_p[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_result[%0d] got %0d want %0d", i, (i < got_p.size()) ? got_p[i] : 16'hxxxx, exp_q[i]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_done_stall();
        int c = 0;
        int nstart = 0;
        bit prev_done = 0;
        clear_q();
        stub_hold     = 6;
        bus.out_ready = 1'b1;
        push_pair(16'd3, 16'd3);
        push_pair(16'd2, 16'd5);
        while (got_p.size() < 2 && c < 300) begin
            @(negedge clk); #1;
            if (bus.mul_start) begin
                nstart++;
                checks++;
                if (prev_done) begin errors++; $display("FAIL stall_start_during_done got start=1 want start only after done low"); end
            end
            prev_done = bus.mul_done;
            c++;
        end
        checks++; if (nstart != 1) begin errors++; $display("FAIL stall_start_count got %0d want 1", nstart); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_p.size() || got_p[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_result[%0d] got %0d want %0d", i, (i < got_p.size()) ? got_p[i] : 16'hxxxx, exp_q[i]);
            end
        end
        repeat (10) @(negedge clk);
        stub_hold = 1;
    endtask

    task automatic test_watchdog();
        int n = 0;
        int lat = 0;
        clear_q();
        stub_never    = 1;
        bus.out_ready = 1'b1;
        push_pair(16'd7, 16'd7);
        #1;
        while (!bus.mul_start && n < 20) begin @(negedge clk); #1; n++; end
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk); #1; lat++;
            if (lat == 10) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wd_busy got %b want 1", bus.busy); end
            end
        end
        checks++; if (lat != 19) begin errors++; $display("FAIL wd_latency got %0d want 19", lat); end
        checks++; if (bus.out_timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout got %b want 1", bus.out_timeout); end
        checks++; if (bus.out_product !== '0) begin errors++; $display("FAIL wd_product got %0d want 0", bus.out_product); end
        @(negedge clk);
        wait_res(1, "wd");
        stub_never = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_watchdog_edge();
        int runs [3] = '{15, 16, 17};
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            int lat = 0;
            int f = runs[k];
            bit want_t = (f > 16);
            logic [W-1:0] want_p = want_t ? 16'd0 : 16'd49;
            int want_lat = want_t ? 19 : f + 3;
            clear_q();
            stub_force    = f;
            bus.out_ready = 1'b1;
            push_pair(16'd7, 16'd7);
            #1;
            while (!bus.mul_start && n < 20) begin @(negedge clk); #1; n++; end
            while (!bus.out_valid && lat < 60) begin @(negedge clk); #1; lat++; end
            checks++; if (lat != want_lat) begin errors++; $display("FAIL wdedge_latency run=%0d got %0d want %0d", f, lat, want_lat); end
            checks++; if (bus.out_timeout !== want_t) begin errors++; $display("FAIL wdedge_timeout run=%0d got %b want %b", f, bus.out_timeout, want_t); end
            checks++; if (bus.out_product !== want_p) begin errors++; $display("FAIL wdedge_product run=%0d got %0d want %0d", f, bus.out_product, want_p); end
            repeat (10) @(negedge clk);
        end
        stub_force = -1;
    endtask

    task automatic test_random();
        localparam int N = 24;
        int c = 0;
        clear_q();
        stub_hold = $urandom_range(1, 3);
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    logic [W-1:0] a = W'($urandom_range(0, 65535));
                    logic [W-1:0] b = W'($urandom_range(0, 12));
                    stub_extra = $urandom_range(0, 2);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    push_pair(a, b);
                end
            end
            begin
                while (got_p.size() < N && c < 4000) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    c++;
                end
            end
        join
        @(negedge clk);
        bus.out_ready = 1'b1;
        checks++; if (got_p.size() != N) begin errors++; $display("FAIL rand_count got %0d want %0d", got_p.size(), N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (i >= got_p.size() || got_p[i] !== exp_q[i] || got_t[i] !== 1'b0) begin
                errors++;
                $display("FAIL rand_result[%0d] got %0d want %0d", i, (i < got_p.size()) ? got_p[i] : 16'hxxxx, exp_q[i]);
            end
        end
        stub_extra = 0;
        stub_hold  = 1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_q();
        bus.out_ready = 1'b1;
        push_pair(16'd5, 16'd9);
        push_pair(16'd6, 16'd2);
        #1;
        while (!bus.mul_start && n < 20) begin @(negedge clk); #1; n++; end
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL rmid_mul_start got %b want 0", bus.mul_start); end
        checks++; if (bus.mul_data !== '0) begin errors++; $display("FAIL rmid_mul_data got %0d want 0", bus.mul_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_product !== '0) begin errors++; $display("FAIL rmid_out_product got %0d want 0", bus.out_product); end
        checks++; if (bus.out_timeout !== 1'b0) begin errors++; $display("FAIL rmid_out_timeout got %b want 0", bus.out_timeout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_result[%0d] got %b want 0", i, bus.out_valid); end
            checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL rmid_no_start[%0d] got %b want 0", i, bus.mul_start); end
        end
        checks++; if (got_p.size() != 0) begin errors++; $display("FAIL rmid_results got %0d want 0", got_p.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero();
        test_backpressure();
        test_done_stall();
        test_watchdog();
        test_watchdog_edge();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
